// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and types for the tone keyboard.
//   HALF_W      - half-period counter width
//   HALF_TABLE  - C4..C5 half-periods in 50 MHz sysclk cycles
//   tone_state_e- player FSM states
//   half_calc   - octave-shifted half-period, never below 1
package tone_pkg;

  localparam int unsigned HALF_W = 17;
  localparam int unsigned KEY_W  = 3;
  localparam int unsigned OCT_W  = 2;

  localparam logic [HALF_W-1:0] HALF_TABLE [0:7] = '{
    17'd95556, 17'd85131, 17'd75843, 17'd71586,
    17'd63776, 17'd56818, 17'd50619, 17'd47778
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } tone_state_e;

  // Each octave step halves the half-period; clamp keeps the divider alive.
  function automatic logic [HALF_W-1:0] half_calc(input logic [KEY_W-1:0] key,
                                                  input logic [OCT_W-1:0] oct);
    logic [HALF_W-1:0] h;
    h = HALF_TABLE[key] >> oct;
    if (h == '0) h = HALF_W'(1);
    return h;
  endfunction

endpackage

// File: rtl/tone_keyboard_if.sv
// tone_keyboard_if: player-side bundle of the tone keyboard.
//   sw, btn, mode, octave - player controls (master drives)
//   out, active, key_idx  - tone output and status (slave drives)
interface tone_keyboard_if
  import tone_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 8
);
  logic [NUM_KEYS-1:0] sw;
  logic                btn;
  logic                mode;
  logic [OCT_W-1:0]    octave;
  logic                out;
  logic                active;
  logic [KEY_W-1:0]    key_idx;

  modport master (output sw, btn, mode, octave, input out, active, key_idx);
  modport slave  (input sw, btn, mode, octave, output out, active, key_idx);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: accepts a new button level only after it has differed from
// the current debounced level for DB_CYCLES consecutive cycles.
//   clk, rst  - clock, synchronous active-high reset
//   btn_i     - synchronised button
//   btn_db_o  - debounced button (registered)
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  // Any return to the debounced level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (btn_i == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      cnt_q <= '0;
      db_q  <= btn_i;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/tone_keyboard.sv
// tone_keyboard: single-key square-wave tone player.
//   sysclk, rst           - 50 MHz clock, synchronous active-high reset
//   sw[NUM_KEYS]          - key switches (lowest set index wins)
//   btn                   - play button (bouncing)
//   mode                  - 0 = hold, 1 = one-shot of NOTE_CYCLES
//   octave[2]             - octave shift up
//   out, active, key_idx  - tone, PLAY status, sounding key
module tone_keyboard
  import tone_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 8,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned NOTE_CYCLES = 25000000
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                btn,
  input  logic                mode,
  input  logic [OCT_W-1:0]    octave,
  output logic                out,
  output logic                active,
  output logic [KEY_W-1:0]    key_idx
);

  localparam int unsigned NOTE_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;

  // Second synchroniser stage and the registered outputs live in this bundle.
  tone_keyboard_if #(.NUM_KEYS(NUM_KEYS)) sync_if ();

  logic [NUM_KEYS-1:0] sw_s1_q;
  logic                btn_s1_q;
  logic                mode_s1_q;
  logic [OCT_W-1:0]    oct_s1_q;

  logic                btn_db;
  logic                db_prev_q;
  tone_state_e         state_q;
  logic                mode_q;
  logic [KEY_W-1:0]    key_q;
  logic [HALF_W-1:0]   half_q;
  logic [HALF_W-1:0]   phase_q;
  logic [NOTE_W-1:0]   note_q;
  logic                out_q;
  logic                active_q;

  logic [KEY_W-1:0]    key_live;
  logic [HALF_W-1:0]   half_live;

  // Two-flop synchronisers for every asynchronous control.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sw_s1_q        <= '0;
      btn_s1_q       <= 1'b0;
      mode_s1_q      <= 1'b0;
      oct_s1_q       <= '0;
      sync_if.sw     <= '0;
      sync_if.btn    <= 1'b0;
      sync_if.mode   <= 1'b0;
      sync_if.octave <= '0;
    end else begin
      sw_s1_q        <= sw;
      btn_s1_q       <= btn;
      mode_s1_q      <= mode;
      oct_s1_q       <= octave;
      sync_if.sw     <= sw_s1_q;
      sync_if.btn    <= btn_s1_q;
      sync_if.mode   <= mode_s1_q;
      sync_if.octave <= oct_s1_q;
    end
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
    .clk      (sysclk),
    .rst      (rst),
    .btn_i    (sync_if.btn),
    .btn_db_o (btn_db)
  );

  // Lowest-index set switch; no switch selects key 0.
  always_comb begin
    key_live = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (sync_if.sw[i]) key_live = KEY_W'(i);
    end
  end

  assign half_live = half_calc(key_live, sync_if.octave);

  // Player FSM with divider; all outputs leave PLAY low/zero.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      db_prev_q <= 1'b0;
      mode_q    <= 1'b0;
      key_q     <= '0;
      half_q    <= HALF_W'(1);
      phase_q   <= '0;
      note_q    <= '0;
      out_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      db_prev_q <= btn_db;
      case (state_q)
        ST_IDLE: begin
          out_q <= 1'b0;
          if (btn_db && !db_prev_q) begin
            state_q  <= ST_PLAY;
            active_q <= 1'b1;
            mode_q   <= sync_if.mode;
            key_q    <= key_live;
            half_q   <= half_live;
            phase_q  <= '0;
            note_q   <= '0;
          end
        end
        ST_PLAY: begin
          if ((!mode_q && !btn_db) ||
              (mode_q && note_q == NOTE_W'(NOTE_CYCLES - 1))) begin
            state_q  <= mode_q ? ST_DONE : ST_IDLE;
            active_q <= 1'b0;
            out_q    <= 1'b0;
            key_q    <= '0;
            phase_q  <= '0;
          end else begin
            if (mode_q) note_q <= note_q + NOTE_W'(1);
            if (!mode_q) key_q <= key_live;
            // Live pitch change restarts the half-period without a toggle.
            if (!mode_q && half_live != half_q) begin
              half_q  <= half_live;
              phase_q <= '0;
            end else if (phase_q == half_q - HALF_W'(1)) begin
              phase_q <= '0;
              out_q   <= ~out_q;
            end else begin
              phase_q <= phase_q + HALF_W'(1);
            end
          end
        end
        ST_DONE: begin
          out_q <= 1'b0;
          if (!btn_db) state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          out_q    <= 1'b0;
          active_q <= 1'b0;
          key_q    <= '0;
        end
      endcase
    end
  end

  assign sync_if.out     = out_q;
  assign sync_if.active  = active_q;
  assign sync_if.key_idx = key_q;

  assign out     = sync_if.out;
  assign active  = sync_if.active;
  assign key_idx = sync_if.key_idx;

endmodule

// File: tb/tb_tone_keyboard.sv
// tb_tone_keyboard: self-checking bench for tone_keyboard with short
// debounce (4) and note (1000) windows.
module tb_tone_keyboard;
  import tone_pkg::*;

  localparam int unsigned NK   = 8;
  localparam int unsigned DB   = 4;
  localparam int unsigned NOTE = 1000;
  localparam int          LAT  = 7;   // 2 sync + 4 debounce + 1 FSM

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_keyboard_if #(.NUM_KEYS(NK)) kb ();

  tone_keyboard #(.NUM_KEYS(NK), .DB_CYCLES(DB), .NOTE_CYCLES(NOTE)) dut (
    .sysclk  (clk),
    .rst     (rst),
    .sw      (kb.sw),
    .btn     (kb.btn),
    .mode    (kb.mode),
    .octave  (kb.octave),
    .out     (kb.out),
    .active  (kb.active),
    .key_idx (kb.key_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] sw;
    int         key;
  } vec_t;

  vec_t vecs [$];
  int   exp_q [$];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ticks until the selected output reaches lvl; -1 if the bound expires.
  task automatic wait_sig(input bit sel_active, input logic lvl, input int bound,
                          output int n);
    n = 0;
    while ((sel_active ? kb.active : kb.out) !== lvl) begin
      if (n >= bound) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic count_busy(input int cycles, output int busy);
    busy = 0;
    repeat (cycles) begin
      tick();
      if (kb.active !== 1'b0 || kb.out !== 1'b0) busy++;
    end
  endtask

  initial begin
    int n;
    int busy;
    int e;
    logic [2:0] key_mid;

    vecs = '{
      '{8'h00, 0}, '{8'h01, 0}, '{8'h80, 7}, '{8'h06, 1},
      '{8'hF0, 4}, '{8'h0C, 2}, '{8'hFF, 0}, '{8'h28, 3}
    };

    rst = 1'b1;
    kb.sw = '0; kb.btn = 1'b0; kb.mode = 1'b0; kb.octave = 2'd0;
    tick(3);
    check("rst_out", kb.out, 0);
    check("rst_active", kb.active, 0);
    check("rst_key_idx", kb.key_idx, 0);
    rst = 1'b0;
    tick(2);

    // Key priority table in hold mode.
    kb.octave = 2'd3;
    foreach (vecs[i]) begin
      kb.sw = vecs[i].sw;
      tick(3);
      exp_q.push_back(vecs[i].key);
      kb.btn = 1'b1;
      wait_sig(1'b1, 1'b1, 50, n);
      e = exp_q.pop_front();
      check("tbl_press_lat", n, LAT);
      check("tbl_key_idx", kb.key_idx, e);
      check("tbl_out_entry", kb.out, 0);
      kb.btn = 1'b0;
      wait_sig(1'b1, 1'b0, 50, n);
      check("tbl_release_lat", n, LAT);
      check("tbl_key_idle", kb.key_idx, 0);
    end

    // S1: key 0, octave 0 held; live octave change to 3 restarts the divider.
    kb.sw = 8'h00; kb.octave = 2'd0; kb.mode = 1'b0;
    tick(3);
    kb.btn = 1'b1;
    wait_sig(1'b1, 1'b1, 50, n);
    check("s1_press_lat", n, LAT);
    busy = 0;
    repeat (200) begin
      tick();
      if (kb.out !== 1'b0) busy++;
    end
    check("s1_out_quiet", busy, 0);
    kb.octave = 2'd3;
    wait_sig(1'b0, 1'b1, 20000, n);
    check("s1_oct3_first_rise", n, 3 + (95556 >> 3));
    kb.btn = 1'b0;
    wait_sig(1'b1, 1'b0, 50, n);
    check("s1_release_lat", n, LAT);
    check("s1_out_on_exit", kb.out, 0);
    tick(5);

    // S2: 3-cycle bounces never pass the debouncer.
    busy = 0;
    repeat (5) begin
      kb.btn = 1'b1;
      repeat (3) begin tick(); if (kb.active !== 1'b0) busy++; end
      kb.btn = 1'b0;
      repeat (3) begin tick(); if (kb.active !== 1'b0) busy++; end
    end
    repeat (10) begin tick(); if (kb.active !== 1'b0) busy++; end
    check("s2_bounce_active", busy, 0);

    // S3: sw=0000_0110, octave 2 -> key 1, half = 85131>>2.
    kb.sw = 8'b0000_0110; kb.octave = 2'd2;
    tick(3);
    kb.btn = 1'b1;
    wait_sig(1'b1, 1'b1, 50, n);
    check("s3_press_lat", n, LAT);
    check("s3_key_idx", kb.key_idx, 1);
    wait_sig(1'b0, 1'b1, 30000, n);
    check("s3_half_period", n, 85131 >> 2);
    kb.btn = 1'b0;
    wait_sig(1'b1, 1'b0, 50, n);
    check("s3_release_lat", n, LAT);
    tick(5);

    // S4: one-shot, button held ~5000 cycles.
    kb.mode = 1'b1; kb.sw = 8'h08; kb.octave = 2'd3;
    tick(3);
    kb.btn = 1'b1;
    wait_sig(1'b1, 1'b1, 50, n);
    check("s4_press_lat", n, LAT);
    n = 0;
    key_mid = '0;
    while (kb.active === 1'b1 && n < 2000) begin
      if (n == 100) begin kb.sw = 8'h01; kb.octave = 2'd0; end
      if (n == 500) key_mid = kb.key_idx;
      tick();
      n++;
    end
    check("s4_note_len", n, NOTE);
    check("s4_key_latched", key_mid, 3);
    check("s4_key_done", kb.key_idx, 0);
    check("s4_out_done", kb.out, 0);
    count_busy(3993, busy);
    check("s4_no_retrigger_held", busy, 0);
    kb.btn = 1'b0;
    count_busy(20, busy);
    check("s4_no_trigger_release", busy, 0);
    kb.btn = 1'b1;
    wait_sig(1'b1, 1'b1, 50, n);
    check("s4_repress_lat", n, LAT);
    check("s4_repress_key", kb.key_idx, 0);
    wait_sig(1'b1, 1'b0, 1100, n);
    check("s4_repress_len", n, NOTE);
    kb.btn = 1'b0;
    tick(10);

    // S6: hold, key 0 -> key 7 mid-tone at octave 3, then S5 reset mid-PLAY.
    kb.mode = 1'b0; kb.sw = 8'h01; kb.octave = 2'd3;
    tick(3);
    kb.btn = 1'b1;
    wait_sig(1'b1, 1'b1, 50, n);
    check("s6_press_lat", n, LAT);
    tick(100);
    kb.sw = 8'h80;
    wait_sig(1'b0, 1'b1, 20000, n);
    check("s6_first_rise", n, 3 + (47778 >> 3));
    check("s6_key_idx", kb.key_idx, 7);
    wait_sig(1'b0, 1'b0, 20000, n);
    check("s6_high_time", n, 47778 >> 3);
    wait_sig(1'b0, 1'b1, 20000, n);
    check("s6_low_time", n, 47778 >> 3);

    rst = 1'b1;
    kb.btn = 1'b0;
    tick();
    rst = 1'b0;
    check("s5_out_after_rst", kb.out, 0);
    check("s5_active_after_rst", kb.active, 0);
    check("s5_key_after_rst", kb.key_idx, 0);
    count_busy(30, busy);
    check("s5_idle_after_rst", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
